mul_arbiter: RTL

Round-robin scheduler that shares one 32x32 sequential shift-add multiplier (33 iterations, `run`/`stall` protocol) between NREQ requesters such as the CPU execute stage and a coprocessor. It accepts one request at a time and holds the operands and `mul_run` stable until the multiplier drops `mul_stall`. It then captures the 64-bit product and returns it to the winner with a valid/ready handshake. It also guarantees the multiplier's iteration counter has returned to zero before the next operation starts.

---
 rtl/mul_arb_pkg.sv | 14 +
 rtl/mul_arbiter_rr_pick.sv | 35 +++
 rtl/mul_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter and its round-robin picker.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int MUL_ITER = 33;
    localparam int MUL_LAT  = 34;
    localparam int NREQ_MAX = 4;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: the first active request strictly after the last grant wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_dist;
    int w_best;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_best = N;
        w_dist = 0;
        for (int i = 0; i < N; i++) begin
            // Distance 0 is the requester immediately after the last grant.
            w_dist = (i + N - 1 - int'(i_last)) % N;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IW'(i);
                o_any  = 1'b1;
            end
        end
    end

    assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential 32x32 shift-add multiplier between NREQ requesters.
// One operation in flight; the product is returned to the winner over valid/ready.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ce,
    input  logic [NREQ-1:0]    i_req_valid,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic [NREQ-1:0]    i_req_u,
    input  logic [NREQ*32-1:0] i_req_x,
    input  logic [NREQ*32-1:0] i_req_y,
    output logic [NREQ-1:0]    o_rsp_valid,
    input  logic [NREQ-1:0]    i_rsp_ready,
    output logic [63:0]        o_rsp_z,
    output logic               o_busy,
    output logic               o_mul_ce,
    output logic               o_mul_run,
    output logic               o_mul_u,
    output logic [31:0]        o_mul_x,
    output logic [31:0]        o_mul_y,
    input  logic               i_mul_stall,
    input  logic [63:0]        i_mul_z
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    logic            r_clean;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_g;
    logic [31:0]     r_x;
    logic [31:0]     r_y;
    logic            r_u;
    logic [63:0]     r_rsp_z;

    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic            w_grant;
    logic            w_resp_done;
    logic [31:0]     w_sel_x;
    logic [31:0]     w_sel_y;
    logic            w_sel_u;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .i_req  (i_req_valid),
        .i_last (r_last),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // Granting is only safe once the multiplier counter is known to be back at zero.
    assign w_grant     = (r_state == ST_IDLE) && r_clean && w_pick_any;
    assign o_req_ready = w_grant ? w_pick_gnt : '0;

    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        w_sel_u = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_idx == IW'(i)) begin
                w_sel_x = i_req_x[i*32 +: 32];
                w_sel_y = i_req_y[i*32 +: 32];
                w_sel_u = i_req_u[i];
            end
        end
    end

    // A ce=1 edge in RESP also clears the counter, so leaving on it is as good as being clean.
    assign w_resp_done = i_rsp_ready[r_g] && (r_clean || i_ce);

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_clean <= 1'b0;
            r_last  <= IW'(NREQ - 1);
            r_g     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_u     <= 1'b0;
            r_rsp_z <= '0;
        end else begin
            if (i_ce && !o_mul_run) begin
                r_clean <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_x     <= w_sel_x;
                        r_y     <= w_sel_y;
                        r_u     <= w_sel_u;
                        r_g     <= w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_clean <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!i_mul_stall) begin
                        r_rsp_z <= i_mul_z;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_mul_run   = (r_state == ST_RUN);
    assign o_mul_ce    = i_ce;
    // The multiplier's u input means signed, the opposite sense of the request flag.
    assign o_mul_u     = ~r_u;
    assign o_mul_x     = r_x;
    assign o_mul_y     = r_y;
    assign o_rsp_z     = r_rsp_z;
    assign o_rsp_valid = (r_state == ST_RESP) ? (NREQ'(1) << r_g) : '0;

endmodule
